// File: rtl/decode_queue.sv
// Buffered RV32I(M) decode stage: a DEPTH-entry fetch FIFO followed by a registered
// decode/output stage with valid/ready on both sides, flush, and illegal-instruction tagging.

package decode_queue_pkg;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011
   } rv32i_opcode_t;

   typedef enum logic [2:0] {
      alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
      alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
   } alu_ops_t;

   typedef enum logic [2:0] {
      beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
   } branch_funct3_t;

   typedef enum logic {a1_rs1_out = 1'b0, a1_pc_out = 1'b1} alumux1_sel_t;

   typedef enum logic [2:0] {
      a2_i_imm = 3'd0, a2_u_imm = 3'd1, a2_b_imm = 3'd2,
      a2_s_imm = 3'd3, a2_j_imm = 3'd4, a2_rs2_out = 3'd5
   } alumux2_sel_t;

   typedef enum logic {cm_rs2_out = 1'b0, cm_i_imm = 1'b1} cmpmux_sel_t;

   typedef enum logic [1:0] {pc_plus4 = 2'd0, pc_alu_out = 2'd1, pc_alu_mod2 = 2'd2} pcmux_sel_t;

   typedef enum logic [3:0] {
      rf_alu_out = 4'd0, rf_br_en = 4'd1, rf_u_imm = 4'd2, rf_lw  = 4'd3, rf_pc_plus4 = 4'd4,
      rf_lb      = 4'd5, rf_lbu   = 4'd6, rf_lh    = 4'd7, rf_lhu = 4'd8
   } regfilemux_sel_t;

   typedef struct packed {
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      alu_ops_t        aluop;
      branch_funct3_t  cmpop;
      alumux1_sel_t    alumux1;
      alumux2_sel_t    alumux2;
      cmpmux_sel_t     cmpmux;
      logic            mem_read;
      logic            mem_write;
      logic            load_pc;
      pcmux_sel_t      pcmux;
      logic            load_regfile;
      regfilemux_sel_t regfilemux;
   } rv32i_control_word;

endpackage

module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  in_instr,
   input  logic [XLEN-1:0]              in_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_instr,
   output logic [XLEN-1:0]              out_pc,
   output rv32i_control_word            out_ctrl,
   output logic                         out_is_muldiv,
   output logic [2:0]                   out_muldiv_op,
   output logic                         out_illegal,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [31:0]       instr_mem [DEPTH];
   logic [XLEN-1:0]   pc_mem    [DEPTH];

   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;

   logic              out_valid_q;
   logic [31:0]       out_instr_q;
   logic [XLEN-1:0]   out_pc_q;
   rv32i_control_word out_ctrl_q;
   logic              out_md_q;
   logic [2:0]        out_mdop_q;
   logic              out_ill_q;

   logic              push, pop;
   logic [31:0]       dec_instr;
   logic [2:0]        f3;
   logic [6:0]        f7;
   rv32i_control_word dec_ctrl;
   logic              dec_md, dec_ill;
   logic [2:0]        dec_mdop;

   // in_ready depends only on occupancy, so a full FIFO refuses even when a pop is under way.
   assign in_ready = (count_q < CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (count_q != '0) && (!out_valid_q || out_ready);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      if (pop)  head_d = head_q + PW'(1);
      if (push) tail_d = tail_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
   end

   assign dec_instr = instr_mem[head_q];
   assign f3        = dec_instr[14:12];
   assign f7        = dec_instr[31:25];

   always_comb begin
      dec_ill              = 1'b0;
      dec_md               = 1'b0;
      dec_ctrl             = '0;
      dec_ctrl.opcode      = dec_instr[6:0];
      dec_ctrl.funct3      = f3;
      dec_ctrl.funct7      = f7;
      dec_ctrl.aluop       = alu_ops_t'(f3);
      dec_ctrl.cmpop       = branch_funct3_t'(f3);
      dec_ctrl.alumux1     = a1_rs1_out;
      dec_ctrl.alumux2     = a2_i_imm;
      dec_ctrl.cmpmux      = cm_rs2_out;
      dec_ctrl.load_pc     = 1'b1;
      dec_ctrl.pcmux       = pc_plus4;
      dec_ctrl.regfilemux  = rf_alu_out;
      case (dec_instr[6:0])
         op_lui: begin
            dec_ctrl.load_regfile = 1'b1;
            dec_ctrl.regfilemux   = rf_u_imm;
         end
         op_auipc: begin
            dec_ctrl.alumux1      = a1_pc_out;
            dec_ctrl.alumux2      = a2_u_imm;
            dec_ctrl.aluop        = alu_add;
            dec_ctrl.load_regfile = 1'b1;
         end
         op_br: begin
            if (f3 == 3'd2 || f3 == 3'd3) dec_ill = 1'b1;
            dec_ctrl.alumux1 = a1_pc_out;
            dec_ctrl.alumux2 = a2_b_imm;
            dec_ctrl.aluop   = alu_add;
         end
         op_load: begin
            dec_ctrl.aluop        = alu_add;
            dec_ctrl.mem_read     = 1'b1;
            dec_ctrl.load_regfile = 1'b1;
            case (f3)
               3'd0:    dec_ctrl.regfilemux = rf_lb;
               3'd1:    dec_ctrl.regfilemux = rf_lh;
               3'd2:    dec_ctrl.regfilemux = rf_lw;
               3'd4:    dec_ctrl.regfilemux = rf_lbu;
               3'd5:    dec_ctrl.regfilemux = rf_lhu;
               default: dec_ill = 1'b1;
            endcase
         end
         op_store: begin
            if (f3 > 3'd2) dec_ill = 1'b1;
            dec_ctrl.alumux2   = a2_s_imm;
            dec_ctrl.aluop     = alu_add;
            dec_ctrl.mem_write = 1'b1;
         end
         op_imm: begin
            dec_ctrl.load_regfile = 1'b1;
            case (f3)
               3'b001: if (f7 != 7'b0000000) dec_ill = 1'b1;
               3'b010, 3'b011: begin
                  dec_ctrl.cmpop      = (f3 == 3'b010) ? blt : bltu;
                  dec_ctrl.cmpmux     = cm_i_imm;
                  dec_ctrl.regfilemux = rf_br_en;
               end
               3'b101: begin
                  if (f7 != 7'b0000000 && f7 != 7'b0100000) dec_ill = 1'b1;
                  dec_ctrl.aluop = f7[5] ? alu_sra : alu_srl;
               end
               default: ;
            endcase
         end
         op_reg: begin
            dec_ctrl.alumux2      = a2_rs2_out;
            dec_ctrl.load_regfile = 1'b1;
            case (f7)
               7'b0000000: begin
                  if (f3 == 3'b010 || f3 == 3'b011) begin
                     dec_ctrl.cmpop      = (f3 == 3'b010) ? blt : bltu;
                     dec_ctrl.regfilemux = rf_br_en;
                  end
               end
               7'b0100000: begin
                  if (f3 == 3'b000)      dec_ctrl.aluop = alu_sub;
                  else if (f3 == 3'b101) dec_ctrl.aluop = alu_sra;
                  else                   dec_ill = 1'b1;
               end
               // M-extension ops share op_reg; the ALU op field is unused for them.
               7'b0000001: begin
                  if (ENABLE_M) dec_md  = 1'b1;
                  else          dec_ill = 1'b1;
               end
               default: dec_ill = 1'b1;
            endcase
         end
         op_jal: begin
            dec_ctrl.alumux1      = a1_pc_out;
            dec_ctrl.alumux2      = a2_j_imm;
            dec_ctrl.aluop        = alu_add;
            dec_ctrl.pcmux        = pc_alu_out;
            dec_ctrl.load_regfile = 1'b1;
            dec_ctrl.regfilemux   = rf_pc_plus4;
         end
         op_jalr: begin
            if (f3 != 3'b000) dec_ill = 1'b1;
            dec_ctrl.aluop        = alu_add;
            dec_ctrl.pcmux        = pc_alu_mod2;
            dec_ctrl.load_regfile = 1'b1;
            dec_ctrl.regfilemux   = rf_pc_plus4;
         end
         default: dec_ill = 1'b1;
      endcase
      if (dec_ill) begin
         dec_ctrl = '0;
         dec_md   = 1'b0;
      end
   end

   assign dec_mdop = dec_md ? f3 : 3'b000;

   always_ff @(posedge clk) begin
      if (push && !rst && !flush) begin
         instr_mem[tail_q] <= in_instr;
         pc_mem[tail_q]    <= in_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
         out_ctrl_q  <= '0;
         out_md_q    <= 1'b0;
         out_mdop_q  <= '0;
         out_ill_q   <= 1'b0;
      end else if (flush) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (pop) begin
            out_valid_q <= 1'b1;
            out_instr_q <= dec_instr;
            out_pc_q    <= pc_mem[head_q];
            out_ctrl_q  <= dec_ctrl;
            out_md_q    <= dec_md;
            out_mdop_q  <= dec_mdop;
            out_ill_q   <= dec_ill;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid     = out_valid_q;
   assign out_instr     = out_instr_q;
   assign out_pc        = out_pc_q;
   assign out_ctrl      = out_ctrl_q;
   assign out_is_muldiv = out_md_q;
   assign out_muldiv_op = out_mdop_q;
   assign out_illegal   = out_ill_q;
   assign count         = count_q;

endmodule
